// File: rtl/branch_predictor_bht.sv
// ============================================================================
//  branch_predictor_bht : direct-mapped 2-bit BHT + BTB, lookup in F, train in E
//  Optional BHT_STATS_EN adds saturating resolved-branch / mispredict counters.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module branch_predictor_bht #(
  parameter int ENTRIES = 64,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] PCF,
  output logic             PredTakenF,
  output logic [WIDTH-1:0] PredTargetF,
  input  logic             BranchE,
  input  logic [WIDTH-1:0] PCE,
  input  logic             TakenE,
  input  logic [WIDTH-1:0] PCTargetE,
  input  logic             PredTakenE,
  input  logic [WIDTH-1:0] PredTargetE,
  output logic             MispredictE,
  output logic [WIDTH-1:0] RedirectPCE,
  output logic [31:0]      BrCountE,
  output logic [31:0]      MissCountE
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = WIDTH - IDXW - 2;

  logic             valid_q  [ENTRIES];
  logic [TAGW-1:0]  tag_q    [ENTRIES];
  logic [WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDXW-1:0]  f_idx, e_idx;
  logic [TAGW-1:0]  f_tag, e_tag;
  logic             f_hit, e_hit;
  logic [1:0]       e_ctr_next;

  assign f_idx = PCF[IDXW+1:2];
  assign f_tag = PCF[WIDTH-1:IDXW+2];
  assign e_idx = PCE[IDXW+1:2];
  assign e_tag = PCE[WIDTH-1:IDXW+2];

  // Byte offset within the word never participates in indexing.
  logic unused_ok;
  assign unused_ok = ^{PCF[1:0], PCE[1:0]};

  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign PredTakenF  = f_hit && ctr_q[f_idx][1];
  assign PredTargetF = PredTakenF ? target_q[f_idx] : '0;

  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  always_comb begin
    e_ctr_next = ctr_q[e_idx];
    if (!e_hit)
      e_ctr_next = TakenE ? 2'b10 : 2'b01;
    else if (TakenE && ctr_q[e_idx] != 2'b11)
      e_ctr_next = ctr_q[e_idx] + 2'b01;
    else if (!TakenE && ctr_q[e_idx] != 2'b00)
      e_ctr_next = ctr_q[e_idx] - 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (BranchE) begin
      valid_q[e_idx] <= 1'b1;
      tag_q[e_idx]   <= e_tag;
      ctr_q[e_idx]   <= e_ctr_next;
      // A not-taken hit keeps the old target; allocation always loads it.
      if (!e_hit || TakenE)
        target_q[e_idx] <= PCTargetE;
    end
  end

  assign MispredictE = BranchE &&
                       ((PredTakenE != TakenE) ||
                        (TakenE && PredTakenE && (PredTargetE != PCTargetE)));
  assign RedirectPCE = TakenE ? PCTargetE : (PCE + {{(WIDTH-3){1'b0}}, 3'd4});

`ifdef BHT_STATS_EN
  logic [31:0] br_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (BranchE && br_cnt_q != 32'hFFFF_FFFF)
        br_cnt_q <= br_cnt_q + 32'd1;
      if (MispredictE && miss_cnt_q != 32'hFFFF_FFFF)
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign BrCountE   = br_cnt_q;
  assign MissCountE = miss_cnt_q;
`else
  assign BrCountE   = '0;
  assign MissCountE = '0;
`endif

endmodule

`default_nettype wire
